// File: rtl/cfeb_rx_pkg.sv
// Shared types and constants for the CFEB frame receiver.
package cfeb_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } rx_state_t;

  // WR_DATA layout: {OVLP, SOF, EOF, data[15:0]}
  localparam int WD_W        = 19;
  localparam int OVLP_BIT    = 18;
  localparam int SOF_BIT     = 17;
  localparam int EOF_BIT     = 16;
  localparam int WPF_DEFAULT = 100;
  localparam int CNT_W       = 10;

endpackage

// File: rtl/cfeb_rx_xchk.sv
// XOR accumulator over frame payload words; compares the running value with a trailer.
module cfeb_rx_xchk (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        acc_en,
  input  logic [15:0] din,
  output logic        match
);

  logic [15:0] sum;

  // A SOF word restarts the sum with itself instead of clearing to zero first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 16'h0000;
    end else if (acc_en) begin
      sum <= sof ? din : (sum ^ din);
    end
  end

  assign match = (sum == din);

endmodule

// File: rtl/cfeb_frame_rx.sv
// CFEB frame receiver: delimits frames, checks length/checksum, tags words for the FIFO.
// Checksum hardware is built only when CFEB_FRAME_RX_XCHK_EN is defined.
module cfeb_frame_rx
  import cfeb_rx_pkg::*;
#(
  parameter int WPF = WPF_DEFAULT,
  parameter int FCW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [15:0]     OUT,
  input  logic            LPUSH_B,
  input  logic            ENDWORD,
  input  logic            OVERLAP,
  input  logic            FIFO_FULL,
  input  logic            CLR_ERR,
  output logic            WR_EN,
  output logic [WD_W-1:0] WR_DATA,
  output logic            FRAME_DONE,
  output logic [FCW-1:0]  FRAME_CNT,
  output logic            LEN_ERR,
  output logic            XCHK_ERR,
  output logic            OVF_ERR,
  output logic            BUSY,
  output logic [1:0]      dbg_state
);

  localparam logic [CNT_W-1:0] WPF_C = CNT_W'(WPF);

  logic [15:0]      out_q;
  logic             push_q, end_q, ovl_q;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovlp, ovlp_n;
  logic             wr_n, sof_n, eof_n, done_n, len_n, ovf_n, chk_n;
  logic [WD_W-1:0]  wd_n;
  logic             trailer_ok;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q  <= 16'h0000;
      push_q <= 1'b0;
      end_q  <= 1'b0;
      ovl_q  <= 1'b0;
    end else begin
      out_q  <= OUT;
      push_q <= ~LPUSH_B;
      end_q  <= ENDWORD;
      ovl_q  <= OVERLAP;
    end
  end

`ifdef CFEB_FRAME_RX_XCHK_EN
  cfeb_rx_xchk u_xchk (
    .clk    (CLK),
    .rst    (RST),
    .sof    (sof_n),
    .acc_en (wr_n & ~end_q),
    .din    (out_q),
    .match  (trailer_ok)
  );
`else
  assign trailer_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ovlp_n  = ovlp;
    wr_n    = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    done_n  = 1'b0;
    len_n   = 1'b0;
    ovf_n   = 1'b0;
    chk_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (push_q) begin
          if (FIFO_FULL) begin
            ovf_n   = 1'b1;
            state_n = end_q ? S_IDLE : S_DROP;
          end else begin
            wr_n   = 1'b1;
            sof_n  = 1'b1;
            eof_n  = end_q;
            ovlp_n = ovl_q;
            cnt_n  = CNT_W'(1);
            if (end_q) len_n = 1'b1;
            else       state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (push_q) begin
          if (FIFO_FULL) begin
            ovf_n   = 1'b1;
            state_n = end_q ? S_IDLE : S_DROP;
          end else begin
            wr_n  = 1'b1;
            eof_n = end_q;
            cnt_n = cnt + 1'b1;
            if (end_q) begin
              state_n = S_IDLE;
              if (cnt_n != WPF_C) len_n  = 1'b1;
              else if (trailer_ok) done_n = 1'b1;
              else                 chk_n  = 1'b1;
            end else if (cnt_n == WPF_C) begin
              len_n   = 1'b1;
              state_n = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (push_q && end_q) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    wd_n = '0;
    if (wr_n) begin
      wd_n[15:0]     = out_q;
      wd_n[OVLP_BIT] = ovlp_n;
      wd_n[SOF_BIT]  = sof_n;
      wd_n[EOF_BIT]  = eof_n;
    end
  end

  // Sticky flags: a new error in the same cycle as CLR_ERR keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ovlp       <= 1'b0;
      WR_EN      <= 1'b0;
      WR_DATA    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      LEN_ERR    <= 1'b0;
      XCHK_ERR   <= 1'b0;
      OVF_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ovlp       <= ovlp_n;
      WR_EN      <= wr_n;
      WR_DATA    <= wd_n;
      FRAME_DONE <= done_n;
      if (done_n) FRAME_CNT <= FRAME_CNT + 1'b1;
      LEN_ERR    <= (LEN_ERR  & ~CLR_ERR) | len_n;
      XCHK_ERR   <= (XCHK_ERR & ~CLR_ERR) | chk_n;
      OVF_ERR    <= (OVF_ERR  & ~CLR_ERR) | ovf_n;
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
